// File: rtl/friet_p_pkg.sv
// Shared definitions for the Friet-P round sequencer: default round count,
// round-0 constant and the controller state encoding.
package friet_p_pkg;

  localparam int         FRIET_P_ROUNDS  = 24;
  localparam logic [4:0] FRIET_P_RC_INIT = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } friet_p_state_e;

endpackage

// File: rtl/friet_p_rc.sv
// Friet-P round-constant LFSR step (purely combinational).
module friet_p_rc (
  input  logic [4:0] rc,
  output logic [4:0] rc_next
);

  assign rc_next = {~rc[4], rc[2], rc[1], rc[0], rc[0] ^ rc[3]};

endmodule

// File: rtl/friet_p_round_ctrl.sv
// Friet-P permutation round sequencer: LOAD strobe, ROUNDS round-enable
// strobes with their round constants, then a one-cycle done pulse.
// Optional build macro FRIET_P_CTRL_ROUND_LIMIT_EN adds a num_rounds input
// that shortens a run to min(num_rounds, ROUNDS) rounds.
module friet_p_round_ctrl
  import friet_p_pkg::*;
#(
  parameter int         ROUNDS  = FRIET_P_ROUNDS,
  parameter logic [4:0] RC_INIT = FRIET_P_RC_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
`ifdef FRIET_P_CTRL_ROUND_LIMIT_EN
  input  logic [4:0] num_rounds,
`endif
  output logic       busy,
  output logic       state_load,
  output logic       round_en,
  output logic [4:0] rc_out,
  output logic [4:0] round_idx,
  output logic       done
);

  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

  friet_p_state_e state_q, state_nxt;
  logic [4:0]     rc_q, rc_step, cnt_q;
  logic           last_round, skip_rounds, accept;

  assign accept = (state_q == ST_IDLE) && start;

  friet_p_rc u_rc (
    .rc      (rc_q),
    .rc_next (rc_step)
  );

`ifdef FRIET_P_CTRL_ROUND_LIMIT_EN
  logic [4:0] limit_q, limit_sel;

  assign limit_sel   = (num_rounds < ROUNDS_W) ? num_rounds : ROUNDS_W;
  assign last_round  = (cnt_q == limit_q - 5'd1);
  assign skip_rounds = (limit_q == 5'd0);

  // Capture the per-run round limit when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         limit_q <= ROUNDS_W;
    else if (accept) limit_q <= limit_sel;
  end
`else
  assign last_round  = (cnt_q == ROUNDS_W - 5'd1);
  assign skip_rounds = 1'b0;
`endif

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and strobe decode.
  // NOTE: every output of this block is defaulted first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state_q;
    busy       = 1'b1;
    state_load = 1'b0;
    round_en   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_load = 1'b1;
        state_nxt  = skip_rounds ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        round_en = ~stall;
        if (!stall && last_round) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Round counter and round-constant register; both freeze on the last round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q  <= RC_INIT;
      cnt_q <= 5'd0;
    end else if (accept) begin
      rc_q  <= RC_INIT;
      cnt_q <= 5'd0;
    end else if (round_en && !last_round) begin
      rc_q  <= rc_step;
      cnt_q <= cnt_q + 5'd1;
    end
  end

  assign rc_out    = rc_q;
  assign round_idx = cnt_q;

endmodule
